// File: rtl/gpu_frame_sequencer.sv
// gpu_frame_sequencer: Avalon-MM master that renders one frame on the voxel GPU
// per start pulse. It programs the camera, then for each chunk of pixels it
// issues start_pixel, rasterize, shade and pixel write-out commands. Every
// command waits for the GPU interrupt and is acknowledged with a status read.
module gpu_frame_sequencer #(
    parameter int unsigned H_RESOLUTION = 320,
    parameter int unsigned V_RESOLUTION = 240,
    parameter int unsigned NUM_SHADERS  = 320,
    parameter int unsigned IRQ_TIMEOUT  = 65535,
    parameter int unsigned VOX_CNT_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [VOX_CNT_BITS-1:0] num_voxels,
    input  logic [VOX_CNT_BITS-1:0] num_palette,
    input  logic [31:0]             fb_base,
    input  logic [479:0]            cam_words,
    output logic                    src_req,
    output logic                    src_sel,
    output logic [VOX_CNT_BITS-1:0] src_index,
    input  logic                    src_valid,
    input  logic [31:0]             src_data,
    output logic [7:0]              gpu_address,
    output logic                    gpu_write,
    output logic [31:0]             gpu_writedata,
    output logic                    gpu_read,
    input  logic [31:0]             gpu_readdata,
    input  logic                    gpu_waitrequest,
    input  logic                    gpu_irq,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code
);
    localparam int unsigned            COLB      = $clog2(H_RESOLUTION);
    localparam logic [31:0]            TOTAL_PIX = 32'(H_RESOLUTION * V_RESOLUTION);
    localparam logic [31:0]            CHUNK_PIX = 32'(NUM_SHADERS);
    localparam logic [31:0]            H_LAST    = 32'(H_RESOLUTION - 1);
    localparam logic [31:0]            TMO       = 32'(IRQ_TIMEOUT);
    localparam logic [VOX_CNT_BITS-1:0] V_ONE    = VOX_CNT_BITS'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_CAM, S_CHUNK, S_FETCH_VOX, S_RASTER, S_FETCH_PAL, S_SHADE,
        S_WRITEOUT, S_WAIT_IRQ, S_ACK, S_ERR_CLR, S_FIN, S_FAIL
    } state_t;

    state_t                  state_q, ret_q;
    logic [VOX_CNT_BITS-1:0] nvox_q, npal_q, idx_q;
    logic [31:0]             fb_q, word_q, chunk_base_q, pix_q, row_q, col_q, tmo_q;
    logic [479:0]            cam_q;
    logic [3:0]              cam_idx_q;

    logic                    src_req_q, src_sel_q;
    logic [VOX_CNT_BITS-1:0] src_index_q;
    logic [7:0]              addr_q;
    logic                    wr_q, rd_q;
    logic [31:0]             wdata_q;
    logic                    busy_q, done_q, error_q;
    logic [1:0]              errc_q;

    logic [31:0]             chunk_next_d, chunk_end_d, pix_next_d, pix_addr_d, tmo_next_d;
    state_t                  post_chunk_d, post_vox_d;
    logic                    wr_done_d, rd_done_d, idx_last_vox_d, idx_last_pal_d;

    assign src_req       = src_req_q;
    assign src_sel       = src_sel_q;
    assign src_index     = src_index_q;
    assign gpu_address   = addr_q;
    assign gpu_write     = wr_q;
    assign gpu_writedata = wdata_q;
    assign gpu_read      = rd_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = errc_q;

    // Chunk bounds, pixel address and the state that follows each phase.
    always_comb begin
        chunk_next_d   = chunk_base_q + CHUNK_PIX;
        chunk_end_d    = (chunk_next_d > TOTAL_PIX) ? TOTAL_PIX : chunk_next_d;
        pix_next_d     = pix_q + 32'd1;
        pix_addr_d     = fb_q | (row_q << (COLB + 1)) | (col_q << 1);
        tmo_next_d     = tmo_q + 32'd1;
        wr_done_d      = wr_q && !gpu_waitrequest;
        rd_done_d      = rd_q && !gpu_waitrequest;
        idx_last_vox_d = (idx_q + V_ONE) == nvox_q;
        idx_last_pal_d = (idx_q + V_ONE) == npal_q;
        post_vox_d     = (npal_q != '0) ? S_FETCH_PAL : S_WRITEOUT;
        post_chunk_d   = (nvox_q != '0) ? S_FETCH_VOX : post_vox_d;
    end

    // Frame sequencing FSM; every output is registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            nvox_q       <= '0;
            npal_q       <= '0;
            idx_q        <= '0;
            fb_q         <= '0;
            word_q       <= '0;
            chunk_base_q <= '0;
            pix_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            tmo_q        <= '0;
            cam_q        <= '0;
            cam_idx_q    <= '0;
            src_req_q    <= 1'b0;
            src_sel_q    <= 1'b0;
            src_index_q  <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            errc_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        nvox_q       <= num_voxels;
                        npal_q       <= num_palette;
                        fb_q         <= fb_base;
                        cam_q        <= cam_words;
                        cam_idx_q    <= '0;
                        idx_q        <= '0;
                        chunk_base_q <= '0;
                        pix_q        <= '0;
                        row_q        <= '0;
                        col_q        <= '0;
                        busy_q       <= 1'b1;
                        error_q      <= 1'b0;
                        errc_q       <= '0;
                        state_q      <= S_CAM;
                    end
                end
                S_CAM: begin
                    if (!wr_q) begin
                        wr_q    <= 1'b1;
                        addr_q  <= 8'h10 + {4'h0, cam_idx_q};
                        wdata_q <= cam_q[{cam_idx_q, 5'd0} +: 32];
                    end else if (!gpu_waitrequest) begin
                        wr_q <= 1'b0;
                        if (cam_idx_q == 4'd14) state_q <= S_CHUNK;
                        else                    cam_idx_q <= cam_idx_q + 4'd1;
                    end
                end
                S_CHUNK: begin
                    if (!wr_q) begin
                        wr_q    <= 1'b1;
                        addr_q  <= 8'h03;
                        wdata_q <= chunk_base_q;
                    end else if (wr_done_d) begin
                        wr_q    <= 1'b0;
                        idx_q   <= '0;
                        ret_q   <= post_chunk_d;
                        tmo_q   <= '0;
                        state_q <= S_WAIT_IRQ;
                    end
                end
                S_FETCH_VOX, S_FETCH_PAL: begin
                    if (!src_req_q) begin
                        src_req_q   <= 1'b1;
                        src_sel_q   <= (state_q == S_FETCH_PAL);
                        src_index_q <= idx_q;
                    end else if (src_valid) begin
                        src_req_q <= 1'b0;
                        word_q    <= src_data;
                        state_q   <= (state_q == S_FETCH_PAL) ? S_SHADE : S_RASTER;
                    end
                end
                S_RASTER, S_SHADE: begin
                    if (!wr_q) begin
                        wr_q    <= 1'b1;
                        addr_q  <= (state_q == S_SHADE) ? 8'h01 : 8'h00;
                        wdata_q <= word_q;
                    end else if (wr_done_d) begin
                        wr_q  <= 1'b0;
                        tmo_q <= '0;
                        if (state_q == S_RASTER) begin
                            idx_q <= idx_last_vox_d ? '0 : idx_q + V_ONE;
                            ret_q <= idx_last_vox_d ? post_vox_d : S_FETCH_VOX;
                        end else begin
                            idx_q <= idx_last_pal_d ? '0 : idx_q + V_ONE;
                            ret_q <= idx_last_pal_d ? S_WRITEOUT : S_FETCH_PAL;
                        end
                        state_q <= S_WAIT_IRQ;
                    end
                end
                S_WRITEOUT: begin
                    if (!wr_q) begin
                        wr_q    <= 1'b1;
                        addr_q  <= 8'h02;
                        wdata_q <= pix_addr_d;
                    end else if (wr_done_d) begin
                        wr_q  <= 1'b0;
                        tmo_q <= '0;
                        pix_q <= pix_next_d;
                        // row/col track pix_q incrementally instead of dividing
                        if (col_q == H_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 32'd1;
                        end else begin
                            col_q <= col_q + 32'd1;
                        end
                        if (pix_next_d == chunk_end_d) begin
                            chunk_base_q <= chunk_next_d;
                            ret_q        <= (pix_next_d == TOTAL_PIX) ? S_FIN : S_CHUNK;
                        end else begin
                            ret_q <= S_WRITEOUT;
                        end
                        state_q <= S_WAIT_IRQ;
                    end
                end
                S_WAIT_IRQ: begin
                    tmo_q <= tmo_next_d;
                    if (gpu_irq) begin
                        state_q <= S_ACK;
                    end else if (tmo_next_d == TMO) begin
                        errc_q  <= 2'd2;
                        state_q <= S_FAIL;
                    end
                end
                S_ACK: begin
                    tmo_q <= tmo_next_d;
                    // timeout only checked between reads so a stalled read is never abandoned
                    if (!rd_q) begin
                        if (tmo_next_d == TMO) begin
                            errc_q  <= 2'd2;
                            state_q <= S_FAIL;
                        end else begin
                            rd_q   <= 1'b1;
                            addr_q <= 8'h0f;
                        end
                    end else if (rd_done_d) begin
                        rd_q <= 1'b0;
                        if (gpu_readdata == 32'd0) begin
                            state_q <= ret_q;
                        end else if (gpu_readdata == 32'd2) begin
                            errc_q  <= 2'd1;
                            state_q <= S_ERR_CLR;
                        end
                    end
                end
                S_ERR_CLR: begin
                    if (!wr_q) begin
                        wr_q    <= 1'b1;
                        addr_q  <= 8'h0f;
                        wdata_q <= 32'd1;
                    end else if (wr_done_d) begin
                        wr_q    <= 1'b0;
                        state_q <= S_FAIL;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    done_q  <= 1'b1;
                    error_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Bench for gpu_frame_sequencer: two instances (4x2 and 3x2 frames, 4-pixel
// chunks, short irq timeout) share one GPU/source model; every GPU write is
// checked against a queue of expected writes built when each frame starts.
module tb_gpu_frame_sequencer;
    localparam logic [31:0] VOX_BASE = 32'hA5A5_0000;
    localparam logic [31:0] PAL_BASE = 32'h5A5A_0000;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic [15:0]  num_voxels = '0, num_palette = '0;
    logic [31:0]  fb_base = '0;
    logic [479:0] cam_w = '0;
    logic         src_valid = 1'b0;
    logic [31:0]  src_data = '0;
    logic [31:0]  gpu_readdata = '0;
    logic         gpu_waitrequest = 1'b0;
    logic         gpu_irq = 1'b0;

    logic        a_src_req, a_src_sel, a_write, a_read, a_busy, a_done, a_error;
    logic [15:0] a_src_index;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_errc;
    logic        b_src_req, b_src_sel, b_write, b_read, b_busy, b_done, b_error;
    logic [15:0] b_src_index;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [1:0]  b_errc;

    logic        sel_b = 1'b0;
    logic        m_src_req, m_src_sel, m_write, m_read, m_busy, m_done, m_error;
    logic [15:0] m_src_index;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_errc;

    assign m_src_req   = sel_b ? b_src_req   : a_src_req;
    assign m_src_sel   = sel_b ? b_src_sel   : a_src_sel;
    assign m_src_index = sel_b ? b_src_index : a_src_index;
    assign m_write     = sel_b ? b_write     : a_write;
    assign m_read      = sel_b ? b_read      : a_read;
    assign m_addr      = sel_b ? b_addr      : a_addr;
    assign m_wdata     = sel_b ? b_wdata     : a_wdata;
    assign m_busy      = sel_b ? b_busy      : a_busy;
    assign m_done      = sel_b ? b_done      : a_done;
    assign m_error     = sel_b ? b_error     : a_error;
    assign m_errc      = sel_b ? b_errc      : a_errc;

    gpu_frame_sequencer #(.H_RESOLUTION(4), .V_RESOLUTION(2), .NUM_SHADERS(4),
                          .IRQ_TIMEOUT(16), .VOX_CNT_BITS(16)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a),
        .num_voxels(num_voxels), .num_palette(num_palette), .fb_base(fb_base), .cam_words(cam_w),
        .src_req(a_src_req), .src_sel(a_src_sel), .src_index(a_src_index),
        .src_valid(src_valid), .src_data(src_data),
        .gpu_address(a_addr), .gpu_write(a_write), .gpu_writedata(a_wdata), .gpu_read(a_read),
        .gpu_readdata(gpu_readdata), .gpu_waitrequest(gpu_waitrequest), .gpu_irq(gpu_irq),
        .busy(a_busy), .done(a_done), .error(a_error), .err_code(a_errc));

    gpu_frame_sequencer #(.H_RESOLUTION(3), .V_RESOLUTION(2), .NUM_SHADERS(4),
                          .IRQ_TIMEOUT(16), .VOX_CNT_BITS(16)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .num_voxels(num_voxels), .num_palette(num_palette), .fb_base(fb_base), .cam_words(cam_w),
        .src_req(b_src_req), .src_sel(b_src_sel), .src_index(b_src_index),
        .src_valid(src_valid), .src_data(src_data),
        .gpu_address(b_addr), .gpu_write(b_write), .gpu_writedata(b_wdata), .gpu_read(b_read),
        .gpu_readdata(gpu_readdata), .gpu_waitrequest(gpu_waitrequest), .gpu_irq(gpu_irq),
        .busy(b_busy), .done(b_done), .error(b_error), .err_code(b_errc));

    always #5 clock = ~clock;

    int unsigned n_checks = 0, n_pass = 0;
    logic [39:0] exp_q[$];
    logic [39:0] sb_e, last_wr;
    int unsigned cyc = 0, cmd_cyc = 0, wr_cnt = 0, rd_cnt = 0, px_cnt = 0;
    int unsigned stall_obs = 0, stall_bad = 0, proto_err = 0, busy_given = 0, irq_cd = 0;
    int unsigned stall_at = 999, stall_len = 0, busy_reads = 0;
    bit          err_inject = 1'b0, irq_clr = 1'b0;
    logic [7:0]  no_irq_cmd = 8'hff, last_cmd = 8'hff, first_wr = 8'h00;

    // GPU slave and source model; logs/scores transfers at posedge, drives responses at negedge.
    always @(posedge clock or negedge clock) begin
        if (!reset_n) begin
            gpu_irq = 1'b0; irq_cd = 0; irq_clr = 1'b0;
            gpu_waitrequest = 1'b0; src_valid = 1'b0;
        end else if (clock) begin
            cyc++;
            if ((start_a || start_b) && !m_busy) begin
                wr_cnt = 0; rd_cnt = 0; px_cnt = 0; stall_obs = 0; stall_bad = 0;
                busy_given = 0; last_cmd = 8'hff; first_wr = 8'h00;
            end
            if (m_write && m_read) proto_err++;
            if (m_write && gpu_waitrequest) begin
                stall_obs++;
                if (m_addr !== 8'h12 || m_wdata !== cam_w[64 +: 32]) stall_bad++;
            end
            if (m_write && !gpu_waitrequest) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_write got=%h_%h required=none", m_addr, m_wdata);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({m_addr, m_wdata} !== sb_e)
                        $display("FAIL sb_write got=%h_%h required=%h_%h", m_addr, m_wdata, sb_e[39:32], sb_e[31:0]);
                    else n_pass++;
                end
                if (wr_cnt == 0) first_wr = m_addr;
                wr_cnt++;
                last_wr = {m_addr, m_wdata};
                if (m_addr == 8'h02) px_cnt++;
                if (m_addr <= 8'h03) begin
                    last_cmd = m_addr;
                    cmd_cyc  = cyc;
                    if (m_addr != no_irq_cmd) irq_cd = 3;
                end
            end
            if (m_read && !gpu_waitrequest) begin
                rd_cnt++;
                irq_clr = 1'b1;
                if (m_addr !== 8'h0f) proto_err++;
                if (gpu_readdata == 32'd1) busy_given++;
            end
        end else begin
            gpu_waitrequest = m_write && (wr_cnt == stall_at) && (stall_obs < stall_len);
            if (irq_clr) begin gpu_irq = 1'b0; irq_clr = 1'b0; end
            if (irq_cd > 0) begin
                irq_cd--;
                if (irq_cd == 0) gpu_irq = 1'b1;
            end
            if (busy_given < busy_reads)                     gpu_readdata = 32'd1;
            else if (err_inject && last_cmd == 8'h00)        gpu_readdata = 32'd2;
            else                                             gpu_readdata = 32'd0;
            src_valid = m_src_req;
            src_data  = (m_src_sel ? PAL_BASE : VOX_BASE) + 32'(m_src_index);
        end
    end

    task automatic set_cfg(input int unsigned nv, input int unsigned np, input logic [31:0] fb);
        num_voxels = 16'(nv); num_palette = 16'(np); fb_base = fb;
        for (int k = 0; k < 15; k++) cam_w[32*k +: 32] = $urandom;
        stall_at = 999; stall_len = 0; busy_reads = 0; err_inject = 1'b0; no_irq_cmd = 8'hff;
    endtask

    // Expected write stream for a complete, error-free frame.
    task automatic push_frame(input int unsigned h, input int unsigned v, input int unsigned ns);
        int unsigned colb;
        colb = 0;
        while ((1 << colb) < h) colb++;
        for (int k = 0; k < 15; k++) exp_q.push_back({8'h10 + 8'(k), cam_w[32*k +: 32]});
        for (int unsigned base = 0; base < h * v; base += ns) begin
            exp_q.push_back({8'h03, 32'(base)});
            for (int unsigned i = 0; i < 32'(num_voxels); i++) exp_q.push_back({8'h00, VOX_BASE + i});
            for (int unsigned i = 0; i < 32'(num_palette); i++) exp_q.push_back({8'h01, PAL_BASE + i});
            for (int unsigned p = base; p < base + ns && p < h * v; p++)
                exp_q.push_back({8'h02, fb_base | ((p / h) << (colb + 1)) | ((p % h) << 1)});
        end
    endtask

    task automatic pulse_start(input bit to_b);
        @(negedge clock);
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int unsigned at);
        seen = 1'b0; at = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clock);
            if (m_done) begin seen = 1'b1; at = cyc; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({a_src_req, a_src_sel, a_src_index, a_addr, a_write, a_wdata, a_read,
             a_busy, a_done, a_error, a_errc} !== '0)
            $display("FAIL reset_a got busy=%b wr=%b rd=%b addr=%h err=%b", a_busy, a_write, a_read, a_addr, a_error);
        else n_pass++;
        n_checks++;
        if ({b_src_req, b_src_sel, b_src_index, b_addr, b_write, b_wdata, b_read,
             b_busy, b_done, b_error, b_errc} !== '0)
            $display("FAIL reset_b got busy=%b wr=%b rd=%b addr=%h err=%b", b_busy, b_write, b_read, b_addr, b_error);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        bit seen; int unsigned at;
        sel_b = 1'b0;
        set_cfg(1, 1, 32'h8000_0000);
        push_frame(4, 2, 4);
        pulse_start(1'b0);
        n_checks++;
        if (m_busy !== 1'b1) $display("FAIL basic_busy got=%b required=1", m_busy); else n_pass++;
        repeat (20) @(negedge clock);
        pulse_start(1'b0);
        wait_done(seen, at);
        n_checks++;
        if (!seen) $display("FAIL basic_done got=timeout required=done"); else n_pass++;
        n_checks++;
        if ({m_error, m_errc} !== 3'b000) $display("FAIL basic_err got=%b/%0d required=0/0", m_error, m_errc); else n_pass++;
        n_checks++;
        if (last_wr !== {8'h02, 32'h8000_0000 | (32'd1 << 3) | (32'd3 << 1)})
            $display("FAIL basic_last_pixel got=%h required=02_8000000e", last_wr);
        else n_pass++;
        n_checks++;
        if (wr_cnt != 29 || rd_cnt != 14) $display("FAIL basic_counts got wr=%0d rd=%0d required wr=29 rd=14", wr_cnt, rd_cnt); else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({m_done, m_busy} !== 2'b00) $display("FAIL basic_done_pulse got done=%b busy=%b required=0/0", m_done, m_busy); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || proto_err != 0)
            $display("FAIL basic_leftover got left=%0d proto=%0d required=0/0", exp_q.size(), proto_err);
        else n_pass++;
    endtask

    task automatic test_partial;
        bit seen; int unsigned at;
        sel_b = 1'b1;
        set_cfg(2, 0, 32'h0040_0000);
        busy_reads = 2;
        push_frame(3, 2, 4);
        pulse_start(1'b1);
        wait_done(seen, at);
        n_checks++;
        if (!seen) $display("FAIL partial_done got=timeout required=done"); else n_pass++;
        n_checks++;
        if ({m_error, m_errc} !== 3'b000) $display("FAIL partial_err got=%b/%0d required=0/0", m_error, m_errc); else n_pass++;
        n_checks++;
        if (px_cnt != 6 || wr_cnt != 27 || rd_cnt != 14)
            $display("FAIL partial_counts got px=%0d wr=%0d rd=%0d required px=6 wr=27 rd=14", px_cnt, wr_cnt, rd_cnt);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL partial_leftover got=%0d required=0", exp_q.size()); else n_pass++;
        @(negedge clock);
        sel_b = 1'b0;
    endtask

    task automatic test_stall;
        bit seen; int unsigned at;
        set_cfg(0, 1, 32'h1000_0000);
        stall_at = 2; stall_len = 5;
        push_frame(4, 2, 4);
        pulse_start(1'b0);
        wait_done(seen, at);
        n_checks++;
        if (!seen || m_error !== 1'b0) $display("FAIL stall_done got seen=%b err=%b required=1/0", seen, m_error); else n_pass++;
        n_checks++;
        if (stall_obs != 5 || stall_bad != 0)
            $display("FAIL stall_hold got cycles=%0d unstable=%0d required=5/0", stall_obs, stall_bad);
        else n_pass++;
        n_checks++;
        if (wr_cnt != 27 || exp_q.size() != 0)
            $display("FAIL stall_writes got wr=%0d left=%0d required=27/0", wr_cnt, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_status_err;
        bit seen; int unsigned at;
        set_cfg(1, 1, 32'h2000_0000);
        err_inject = 1'b1;
        for (int k = 0; k < 15; k++) exp_q.push_back({8'h10 + 8'(k), cam_w[32*k +: 32]});
        exp_q.push_back({8'h03, 32'd0});
        exp_q.push_back({8'h00, VOX_BASE});
        exp_q.push_back({8'h0f, 32'd1});
        pulse_start(1'b0);
        wait_done(seen, at);
        n_checks++;
        if (!seen) $display("FAIL status_done got=timeout required=done"); else n_pass++;
        n_checks++;
        if ({m_error, m_errc} !== 3'b101) $display("FAIL status_err got=%b/%0d required=1/1", m_error, m_errc); else n_pass++;
        repeat (20) @(negedge clock);
        n_checks++;
        if (wr_cnt != 18 || rd_cnt != 2 || exp_q.size() != 0 || m_busy !== 1'b0)
            $display("FAIL status_quiet got wr=%0d rd=%0d left=%0d busy=%b required 18/2/0/0", wr_cnt, rd_cnt, exp_q.size(), m_busy);
        else n_pass++;
        err_inject = 1'b0;
    endtask

    task automatic test_timeout;
        bit seen; int unsigned at;
        set_cfg(1, 1, 32'h3000_0000);
        no_irq_cmd = 8'h03;
        for (int k = 0; k < 15; k++) exp_q.push_back({8'h10 + 8'(k), cam_w[32*k +: 32]});
        exp_q.push_back({8'h03, 32'd0});
        pulse_start(1'b0);
        wait_done(seen, at);
        n_checks++;
        if (!seen) $display("FAIL timeout_done got=timeout required=done"); else n_pass++;
        n_checks++;
        if ({m_error, m_errc} !== 3'b110) $display("FAIL timeout_err got=%b/%0d required=1/2", m_error, m_errc); else n_pass++;
        n_checks++;
        if (at - cmd_cyc != 17) $display("FAIL timeout_cycles got=%0d required=17", at - cmd_cyc); else n_pass++;
        n_checks++;
        if (wr_cnt != 16 || rd_cnt != 0 || exp_q.size() != 0)
            $display("FAIL timeout_traffic got wr=%0d rd=%0d left=%0d required 16/0/0", wr_cnt, rd_cnt, exp_q.size());
        else n_pass++;
        no_irq_cmd = 8'hff;
    endtask

    task automatic test_reset_mid;
        bit seen; int unsigned at;
        set_cfg(1, 1, 32'h4000_0000);
        push_frame(4, 2, 4);
        pulse_start(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clock);
            seen = (px_cnt >= 2);
        end
        n_checks++;
        if (!seen) $display("FAIL rstmid_reach got=timeout required=writeout"); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a_src_req, a_src_sel, a_src_index, a_addr, a_write, a_wdata, a_read,
             a_busy, a_done, a_error, a_errc} !== '0)
            $display("FAIL rstmid_async got busy=%b wr=%b rd=%b addr=%h", a_busy, a_write, a_read, a_addr);
        else n_pass++;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        push_frame(4, 2, 4);
        pulse_start(1'b0);
        wait_done(seen, at);
        n_checks++;
        if (!seen || m_error !== 1'b0) $display("FAIL rstmid_rerun got seen=%b err=%b required=1/0", seen, m_error); else n_pass++;
        n_checks++;
        if (first_wr !== 8'h10 || exp_q.size() != 0)
            $display("FAIL rstmid_cam got first=%h left=%0d required=10/0", first_wr, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_partial;
        test_stall;
        test_status_err;
        test_timeout;
        test_reset_mid;
        repeat (5) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gpu_frame_sequencer.md
Name: gpu_frame_sequencer

Overview:
- Drives the voxel GPU's 8-bit-address Avalon-MM control slave as its master, to render one complete frame per `start` pulse.
- Per frame: programs the 15 camera registers once. Then, per chunk of NUM_SHADERS pixels: coordinate/raycast, rasterize every voxel, shade every palette entry, write out every pixel of the chunk.
- After every GPU command it waits for `irq`, acknowledges by reading status, and recovers from GPU error state.
- Sits between the host-side frame controller and the GPU; voxel and palette words arrive over a request/response source port.

Parameters:
H_RESOLUTION, 320, frame width in pixels
V_RESOLUTION, 240, frame height in pixels
NUM_SHADERS, 320, pixels processed per chunk
IRQ_TIMEOUT, 65535, max cycles to wait for irq before flagging timeout
VOX_CNT_BITS, 16, width of voxel/palette count inputs

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle (ignored when busy)
num_voxels  in  VOX_CNT_BITS  voxel words to rasterize per chunk; sampled at start
num_palette  in  VOX_CNT_BITS  palette words to shade per chunk; sampled at start
fb_base  in  32  framebuffer base address; sampled at start
cam_words  in  480  15 camera words; word k → GPU address 0x10+k, word k at bits [32k+31:32k]; sampled at start
src_req  out  1  source fetch request; held until src_valid
src_sel  out  1  0 = voxel list, 1 = palette
src_index  out  VOX_CNT_BITS  word index being fetched
src_valid  in  1  src_data valid; completes the fetch
src_data  in  32  fetched word
gpu_address  out  8  GPU slave address
gpu_write  out  1  GPU write strobe
gpu_writedata  out  32  GPU write data
gpu_read  out  1  GPU read strobe
gpu_readdata  in  32  GPU read data; valid while gpu_read=1 and gpu_waitrequest=0
gpu_waitrequest  in  1  GPU stall
gpu_irq  in  1  GPU command-complete interrupt
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end, success or error
error  out  1  sticky error flag; cleared by next accepted start
err_code  out  2  0 none, 1 GPU status=2, 2 irq timeout

Behaviour:
- Reset (any time, including mid-frame): state IDLE; all outputs 0; counters 0. No Avalon transfer is completed after reset_n falls.
- Avalon master rules:
  - At most one of gpu_write/gpu_read is asserted at a time.
  - Address, data and strobe are held stable while gpu_waitrequest=1.
  - The transfer completes on the first cycle the strobe is high with waitrequest=0; the strobe drops the next cycle.
- Command = one GPU write to 0x00 (voxel), 0x01 (palette), 0x02 (pixel) or 0x03 (start_pixel), followed by WAIT_IRQ then ACK.
- WAIT_IRQ:
  - Counts cycles from 0; irq seen → ACK.
  - Count reaches IRQ_TIMEOUT with no irq → err_code=2, go to FAIL.
  - irq asserted in the same cycle as the command write completes is ignored, so a stale irq is not acted on.
- ACK: read 0x0f.
  - readdata=0 → resume the return state.
  - readdata=2 → err_code=1, go to ERR_CLR: write 0x0f with data 1, then FAIL.
  - readdata=1 → repeat the ACK read; this counts against the same timeout counter.
- States: IDLE → CAM → CHUNK → (FETCH_VOX → RASTER)* → (FETCH_PAL → SHADE)* → WRITEOUT* → next CHUNK or FIN; any error → FAIL.
  - CAM: 15 back-to-back writes to 0x10..0x1e; no irq wait.
  - CHUNK: write 0x03 with chunk_base (0, NUM_SHADERS, 2·NUM_SHADERS, ...).
  - FETCH_VOX: src_sel=0, src_index=v; src_data is latched on src_valid, then RASTER writes it to 0x00. v runs 0..num_voxels-1. num_voxels=0 skips rasterize.
  - FETCH_PAL / SHADE: same pattern to 0x01, index 0..num_palette-1. num_palette=0 skips shade.
  - WRITEOUT: for p = chunk_base .. min(chunk_base+NUM_SHADERS, H·V)-1 with row=p/H, col=p%H (incremental row/col counters, no divider), write 0x02 with fb_base | row<<(COLB+1) | col<<1. COLB=$clog2(H_RESOLUTION).
  - FIN: done=1 for one cycle → IDLE.
  - FAIL: error=1, done=1 for one cycle → IDLE.
- Final chunk may be partial when H·V is not a multiple of NUM_SHADERS.
- start while busy: ignored; no effect on the frame in flight.
- busy=1 from the cycle after an accepted start until the cycle done pulses inclusive.

Test Plan:
- H=4,V=2,NUM_SHADERS=4, voxels=1, palette=1, GPU model raises irq 3 cycles after each command, status 0 → exactly 15 cam writes; 2× (0x03 then 0x00, 0x01, four 0x02); start_pixel values 0 then 4; last pixel address fb_base|1<<3|3<<1; done=1, error=0.
- H=3,V=2,NUM_SHADERS=4 → chunks of 4 and 2 pixels; 6 pixel writes total; second start_pixel=4.
- gpu_waitrequest held high 5 cycles on the 3rd cam write → addr 0x12 and data held stable throughout; no duplicate write.
- Status read returns 2 after the first rasterize → write 0x0f data 1; err_code=1, error=1, done pulse; no further commands issued.
- irq never asserted after 0x03, IRQ_TIMEOUT=16 → FAIL at 16 cycles, err_code=2.
- reset_n low mid-WRITEOUT → all outputs 0 asynchronously; the next start re-runs the camera writes from 0x10.
